// File: rtl/runway_scheduler.sv
// runway_scheduler
// Grants a two-runway airfield to four aircraft slots. Requests are latched
// into a pending vector; one grant per clock goes to a free runway (A before
// B), with the winning slot chosen round-robin. Each grant occupies its
// runway for OCC_CYCLES clocks unless the runway is vacated early.
//
// Optional feature macro: RUNWAY_EMERG_EN
//   When defined, an extra 4-bit emerg input qualifies req. Emergency slots
//   are served before all others (lowest index first) without moving the
//   round-robin pointer.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous active-high reset
//   req[3:0]   one-cycle request pulse per aircraft slot
//   vac_a/b    runway A/B vacated early (ignored when the runway is idle)
//   emerg[3:0] emergency qualifier, sampled with req (RUNWAY_EMERG_EN only)
//   gnt_valid  registered one-cycle grant strobe
//   gnt_id     granted slot (valid with gnt_valid)
//   gnt_rwy    granted runway, 0=A 1=B (valid with gnt_valid)
//   busy_a/b   runway occupied
//   w          at least one request still pending
module runway_scheduler #(
  parameter int unsigned OCC_CYCLES = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic       vac_a,
  input  logic       vac_b,
`ifdef RUNWAY_EMERG_EN
  input  logic [3:0] emerg,
`endif
  output logic       gnt_valid,
  output logic [1:0] gnt_id,
  output logic       gnt_rwy,
  output logic       busy_a,
  output logic       busy_b,
  output logic       w
);

  // Counter load value: busy stays high for the load edge plus OCC_CYCLES-1
  // further edges, clearing at the edge where the counter reads zero.
  localparam logic [3:0] OCC_LOAD = 4'(OCC_CYCLES - 1);

  logic [3:0] pending_reg, pending_next, cand;
  logic [1:0] ptr_reg, ptr_next;
  logic [1:0] busy_vec;
  logic [1:0] vac;
  logic       grant;
  logic       win_rwy;
  logic [1:0] win_id;
  logic       rr_found;
  logic [1:0] rr_id, rr_idx;

`ifdef RUNWAY_EMERG_EN
  logic [3:0] epend_reg, epend_next, ecand;
  logic       em_found;
  logic [1:0] em_id;
`endif

  assign vac    = {vac_b, vac_a};
  assign busy_a = busy_vec[0];
  assign busy_b = busy_vec[1];

  always_comb begin
    cand     = pending_reg | req;
    rr_found = 1'b0;
    rr_id    = 2'd0;
    rr_idx   = 2'd0;
    // Scan from ptr upward with 2-bit wraparound; first hit wins.
    for (int i = 0; i < 4; i++) begin
      rr_idx = ptr_reg + 2'(i);
      if (!rr_found && cand[rr_idx]) begin
        rr_found = 1'b1;
        rr_id    = rr_idx;
      end
    end

    // Decisions use the registered busy flags, so a runway freed this edge
    // (timeout or vacate) cannot be re-granted until the next edge.
    grant   = (cand != 4'd0) && (busy_vec != 2'b11);
    win_rwy = busy_vec[0];

`ifdef RUNWAY_EMERG_EN
    ecand    = epend_reg | (req & emerg);
    em_found = 1'b0;
    em_id    = 2'd0;
    // Descending scan so the lowest set index is the one left in em_id.
    for (int i = 3; i >= 0; i--) begin
      if (ecand[i]) begin
        em_found = 1'b1;
        em_id    = 2'(i);
      end
    end
    win_id   = em_found ? em_id : rr_id;
    ptr_next = (grant && !em_found) ? rr_id + 2'd1 : ptr_reg;
    epend_next = ecand;
    if (grant) epend_next[win_id] = 1'b0;
`else
    win_id   = rr_id;
    ptr_next = grant ? rr_id + 2'd1 : ptr_reg;
`endif

    pending_next = cand;
    if (grant) pending_next[win_id] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg <= 4'd0;
      ptr_reg     <= 2'd0;
      gnt_valid   <= 1'b0;
      gnt_id      <= 2'd0;
      gnt_rwy     <= 1'b0;
      w           <= 1'b0;
    end else begin
      pending_reg <= pending_next;
      ptr_reg     <= ptr_next;
      gnt_valid   <= grant;
      w           <= |pending_next;
      if (grant) begin
        gnt_id  <= win_id;
        gnt_rwy <= win_rwy;
      end
    end
  end

`ifdef RUNWAY_EMERG_EN
  always_ff @(posedge clk) begin
    if (rst) epend_reg <= 4'd0;
    else     epend_reg <= epend_next;
  end
`endif

  // One occupancy tracker per runway (gi=0 is A, gi=1 is B).
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rwy
      logic       busy_reg;
      logic [3:0] cnt_reg;
      logic       load;

      assign load         = grant && (win_rwy == 1'(gi));
      assign busy_vec[gi] = busy_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          busy_reg <= 1'b0;
          cnt_reg  <= 4'd0;
        end else if (load) begin
          busy_reg <= 1'b1;
          cnt_reg  <= OCC_LOAD;
        end else if (busy_reg && (vac[gi] || cnt_reg == 4'd0)) begin
          busy_reg <= 1'b0;
          cnt_reg  <= 4'd0;
        end else if (busy_reg) begin
          cnt_reg  <= cnt_reg - 4'd1;
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_runway_scheduler.sv
// Scoreboard bench for runway_scheduler. Stimulus pushes the expected grant
// (edge number, slot, runway) into a queue; a negedge monitor pops and
// compares every grant strobe. A second instance with OCC_CYCLES=1 checks
// the alternating-runway case directly.
module tb_runway_scheduler;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, req1;
  logic       vac_a, vac_b;
  logic       gnt_valid, gnt_rwy, busy_a, busy_b, w;
  logic [1:0] gnt_id;
  logic       gnt_valid1, gnt_rwy1, busy_a1, busy_b1, w1;
  logic [1:0] gnt_id1;
`ifdef RUNWAY_EMERG_EN
  logic [3:0] emerg, emerg1;
`endif

  int tests = 0;
  int fails = 0;
  int edge_cnt = 0;

  typedef struct {
    int cyc;
    int id;
    int rwy;
  } exp_t;
  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  runway_scheduler #(.OCC_CYCLES(15)) dut (
    .clk(clk), .rst(rst), .req(req), .vac_a(vac_a), .vac_b(vac_b),
`ifdef RUNWAY_EMERG_EN
    .emerg(emerg),
`endif
    .gnt_valid(gnt_valid), .gnt_id(gnt_id), .gnt_rwy(gnt_rwy),
    .busy_a(busy_a), .busy_b(busy_b), .w(w)
  );

  runway_scheduler #(.OCC_CYCLES(1)) dut1 (
    .clk(clk), .rst(rst), .req(req1), .vac_a(1'b0), .vac_b(1'b0),
`ifdef RUNWAY_EMERG_EN
    .emerg(emerg1),
`endif
    .gnt_valid(gnt_valid1), .gnt_id(gnt_id1), .gnt_rwy(gnt_rwy1),
    .busy_a(busy_a1), .busy_b(busy_b1), .w(w1)
  );

  task automatic chk(input string nm, input int act, input int exp_v);
    tests++;
    if (act != exp_v) begin
      fails++;
      $display("[TB] FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp_v, edge_cnt);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_gnt(input int cyc, input int id, input int rwy);
    exp_t e;
    e.cyc = cyc;
    e.id  = id;
    e.rwy = rwy;
    sb.push_back(e);
  endtask

  // Monitor: every grant strobe must match the head of the queue in edge
  // number, slot and runway; queue entries whose edge has passed are misses.
  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].cyc < edge_cnt) begin
      e = sb.pop_front();
      tests++;
      fails++;
      $display("[TB] FAIL missing_grant: none at edge %0d, expected slot %0d rwy %0d", e.cyc, e.id, e.rwy);
    end
    if (gnt_valid) begin
      if (sb.size() == 0 || sb[0].cyc != edge_cnt) begin
        tests++;
        fails++;
        $display("[TB] FAIL unexpected_grant: slot %0d rwy %0d at edge %0d, expected none", gnt_id, gnt_rwy, edge_cnt);
      end else begin
        e = sb.pop_front();
        chk("gnt_id", int'(gnt_id), e.id);
        chk("gnt_rwy", int'(gnt_rwy), e.rwy);
        $display("[TB] grant edge %0d slot %0d rwy %0d", edge_cnt, gnt_id, gnt_rwy);
      end
    end
  end

  initial begin
    int e0;
    rst = 1'b1; req = 4'd0; req1 = 4'd0; vac_a = 1'b0; vac_b = 1'b0;
`ifdef RUNWAY_EMERG_EN
    emerg = 4'd0; emerg1 = 4'd0;
`endif
    tick(); tick();
    chk("rst_gnt_valid", int'(gnt_valid), 0);
    chk("rst_busy_a", int'(busy_a), 0);
    chk("rst_busy_b", int'(busy_b), 0);
    chk("rst_w", int'(w), 0);
    rst = 1'b0;

    // OCC_CYCLES=1 instance: request every edge alternates A, B, A, B.
    req1 = 4'b0001;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("occ1_gnt_valid", int'(gnt_valid1), 1);
      chk("occ1_gnt_rwy", int'(gnt_rwy1), k % 2);
      chk("occ1_busy_a", int'(busy_a1), (k % 2 == 0) ? 1 : 0);
      chk("occ1_busy_b", int'(busy_b1), (k % 2 == 1) ? 1 : 0);
      chk("occ1_w", int'(w1), 0);
    end
    req1 = 4'd0;
    tick();
    chk("occ1_idle_gnt", int'(gnt_valid1), 0);
    chk("occ1_idle_busy_b", int'(busy_b1), 0);

    // Single request: grant on A next edge, A busy exactly 15 cycles.
    e0 = edge_cnt + 1;
    expect_gnt(e0, 0, 0);
    req = 4'b0001;
    tick();
    req = 4'd0;
    chk("single_w", int'(w), 0);
    chk("single_busy_b", int'(busy_b), 0);
    for (int k = 0; k < 16; k++) begin
      if (k > 0) tick();
      chk("single_busy_a", int'(busy_a), (k < 15) ? 1 : 0);
    end

    // All four request at once (ptr back at 0 after reset).
    rst = 1'b1; tick(); rst = 1'b0;
    e0 = edge_cnt + 1;
    expect_gnt(e0, 0, 0);
    expect_gnt(e0 + 1, 1, 1);
    expect_gnt(e0 + 16, 2, 0);
    expect_gnt(e0 + 17, 3, 1);
    req = 4'b1111;
    tick();
    req = 4'd0;
    chk("all4_w", int'(w), 1);
    repeat (17) tick();
    chk("all4_w_drained", int'(w), 0);
    chk("all4_busy_a", int'(busy_a), 1);
    chk("all4_busy_b", int'(busy_b), 1);
    repeat (16) tick();
    chk("all4_idle_a", int'(busy_a), 0);
    chk("all4_idle_b", int'(busy_b), 0);

    // Early vacate of B hands it to the pending slot 3 on the next edge.
    e0 = edge_cnt + 1;
    expect_gnt(e0, 0, 0);
    expect_gnt(e0 + 1, 1, 1);
    req = 4'b0011;
    tick();
    req = 4'b1000;
    tick();
    tick();
    req = 4'd0;
    chk("vac_w_pending", int'(w), 1);
    tick(); tick();
    vac_b = 1'b1;
    tick();
    vac_b = 1'b0;
    chk("vac_busy_b", int'(busy_b), 0);
    chk("vac_busy_a_kept", int'(busy_a), 1);
    expect_gnt(edge_cnt + 1, 3, 1);
    tick();
    chk("vac_regrant_busy_b", int'(busy_b), 1);
    vac_a = 1'b1;
    tick();
    vac_a = 1'b0;
    chk("vac_busy_a", int'(busy_a), 0);

    // Reset mid-occupancy with two slots pending.
    expect_gnt(edge_cnt + 1, 1, 0);
    req = 4'b1110;
    tick();
    req = 4'd0;
    chk("pre_rst_w", int'(w), 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_gnt_valid", int'(gnt_valid), 0);
    chk("mid_rst_gnt_id", int'(gnt_id), 0);
    chk("mid_rst_gnt_rwy", int'(gnt_rwy), 0);
    chk("mid_rst_busy_a", int'(busy_a), 0);
    chk("mid_rst_busy_b", int'(busy_b), 0);
    chk("mid_rst_w", int'(w), 0);
    repeat (5) tick();
    e0 = edge_cnt + 1;
    expect_gnt(e0, 0, 0);
    expect_gnt(e0 + 1, 3, 1);
    req = 4'b1001;
    tick();
    req = 4'd0;
    tick();
    chk("post_rst_w", int'(w), 0);

`ifdef RUNWAY_EMERG_EN
    // Emergency slot 3 beats slot 0 (ptr=0) when A frees first.
    rst = 1'b1; tick(); rst = 1'b0;
    e0 = edge_cnt + 1;
    expect_gnt(e0, 2, 0);
    expect_gnt(e0 + 1, 3, 1);
    expect_gnt(e0 + 16, 3, 0);
    expect_gnt(e0 + 17, 0, 1);
    req = 4'b1100;
    tick();
    req = 4'd0;
    tick();
    req = 4'b1001;
    emerg = 4'b1000;
    tick();
    req = 4'd0;
    emerg = 4'd0;
    repeat (16) tick();
    chk("emerg_w", int'(w), 0);
`endif

    tick(); tick();
    chk("scoreboard_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
